// File: rtl/sum_arbiter_if.sv
// Handshake bundle between two operand requesters, the sum arbiter and the result consumer.
// The arbiter takes the slave view; requesters and consumer together drive the master view.
interface sum_arbiter_if #(
    parameter int WIDTH = 3
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic             res_valid;
    logic [WIDTH:0]   res_data;
    logic             res_id;
    logic             res_ready;
    logic [7:0]       res_count;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_data, res_id, res_count,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_data, res_id, res_count,
        output res_ready
    );
endinterface

// File: rtl/sum_arbiter.sv
// Two-requester round-robin arbiter feeding one shared adder into a single-entry result register.
//   state | meaning
//   IDLE  | no result held; the granted requester may transfer its operand pair
//   HOLD  | result held on res_*; both requesters stalled until the consumer takes it
module sum_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic clock,
    input  logic reset,
    sum_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant;
    logic             ready0;
    logic             ready1;
    logic             transfer;
    logic             deliver;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   res_data_q;
    logic             res_id_q;
    logic [7:0]       count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready0     = 1'b0;
        ready1     = 1'b0;
        deliver    = 1'b0;

        // On a tie the requester that did not win last time goes next.
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (!bus.req0_valid) begin
            grant = 1'b1;
        end

        case (state)
            IDLE: begin
                if (!reset) begin
                    ready0 = bus.req0_valid && !grant;
                    ready1 = bus.req1_valid && grant;
                end
                if (ready0 || ready1) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    deliver    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        transfer = ready0 || ready1;
    end

    assign op_a = grant ? bus.req1_a : bus.req0_a;
    assign op_b = grant ? bus.req1_b : bus.req0_b;
    assign sum  = {1'b0, op_a} + {1'b0, op_b};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            last_grant <= 1'b1;
            count_q    <= 8'd0;
        end else begin
            if (transfer) begin
                res_data_q <= sum;
                res_id_q   <= grant;
                last_grant <= grant;
            end
            if (deliver) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = (state == HOLD);
    assign bus.res_data   = res_data_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_count  = count_q;
endmodule

// File: tb/tb_sum_arbiter.sv
// Self-checking bench for sum_arbiter: vector table, directed corner sequences and
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_sum_arbiter;
    localparam int W = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sum_arbiter_if #(.WIDTH(W)) bus_if ();

    sum_arbiter #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: one optional held result plus fairness memory and a delivery count.
    bit m_held;
    int m_data;
    int m_id;
    int m_last;
    int m_count;
    bit e_r0;
    bit e_r1;

    typedef struct {
        bit         v0;
        logic [2:0] a0;
        logic [2:0] b0;
        bit         v1;
        logic [2:0] a1;
        logic [2:0] b1;
        int         exp_data;
        int         exp_id;
    } vec_t;

    vec_t vecs[7];
    int   id_seen[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_held  = 1'b0;
        m_data  = 0;
        m_id    = 0;
        m_last  = 1;
        m_count = 0;
    endfunction

    function automatic void model_ready();
        int winner;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (reset || m_held) return;
        if (bus_if.req0_valid && bus_if.req1_valid) begin
            winner = 1 - m_last;
            e_r0 = (winner == 0);
            e_r1 = (winner == 1);
        end else if (bus_if.req0_valid) begin
            e_r0 = 1'b1;
        end else if (bus_if.req1_valid) begin
            e_r1 = 1'b1;
        end
    endfunction

    function automatic void model_edge();
        if (reset) begin
            model_clear();
        end else if (m_held) begin
            if (bus_if.res_ready) begin
                m_held  = 1'b0;
                m_count = (m_count + 1) % 256;
            end
        end else if (e_r0 || e_r1) begin
            m_held = 1'b1;
            m_id   = e_r1 ? 1 : 0;
            m_last = m_id;
            m_data = e_r1 ? int'(bus_if.req1_a) + int'(bus_if.req1_b)
                          : int'(bus_if.req0_a) + int'(bus_if.req0_b);
        end
    endfunction

    // Inputs are set at the falling edge; compare after settling, then advance one clock.
    task automatic cycle();
        #1;
        if (reset) model_clear();
        model_ready();
        check("req0_ready", 32'(bus_if.req0_ready), 32'(e_r0));
        check("req1_ready", 32'(bus_if.req1_ready), 32'(e_r1));
        check("res_valid",  32'(bus_if.res_valid),  32'(m_held));
        check("res_data",   32'(bus_if.res_data),   32'(m_data));
        check("res_id",     32'(bus_if.res_id),     32'(m_id));
        check("res_count",  32'(bus_if.res_count),  32'(m_count));
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus_if.req0_valid = 1'b0;
        bus_if.req0_a     = '0;
        bus_if.req0_b     = '0;
        bus_if.req1_valid = 1'b0;
        bus_if.req1_a     = '0;
        bus_if.req1_b     = '0;
        bus_if.res_ready  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'd3, 3'd4, 1'b0, 3'd0, 3'd0,  7, 0};
        vecs[1] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 3'd7, 14, 1};
        vecs[2] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 3'd1,  8, 1};
        vecs[3] = '{1'b1, 3'd0, 3'd0, 1'b0, 3'd5, 3'd5,  0, 0};
        vecs[4] = '{1'b1, 3'd7, 3'd7, 1'b0, 3'd1, 3'd1, 14, 0};
        vecs[5] = '{1'b0, 3'd6, 3'd6, 1'b1, 3'd5, 3'd2,  7, 1};
        vecs[6] = '{1'b1, 3'd4, 3'd4, 1'b0, 3'd3, 3'd3,  8, 0};

        idle_inputs();
        model_clear();
        @(negedge clock);
        do_reset();

        // Single-requester vectors: transfer, then result visible next cycle and delivered.
        for (int i = 0; i < 7; i++) begin
            bus_if.req0_valid = vecs[i].v0;
            bus_if.req0_a     = vecs[i].a0;
            bus_if.req0_b     = vecs[i].b0;
            bus_if.req1_valid = vecs[i].v1;
            bus_if.req1_a     = vecs[i].a1;
            bus_if.req1_b     = vecs[i].b1;
            bus_if.res_ready  = 1'b1;
            cycle();
            bus_if.req0_valid = 1'b0;
            bus_if.req1_valid = 1'b0;
            #1;
            check("vec_res_valid", 32'(bus_if.res_valid), 32'd1);
            check("vec_res_data",  32'(bus_if.res_data),  32'(vecs[i].exp_data));
            check("vec_res_id",    32'(bus_if.res_id),    32'(vecs[i].exp_id));
            cycle();
        end
        check("vec_count", 32'(bus_if.res_count), 32'd7);

        // Tie fairness right after reset: ids alternate starting with requester 0.
        idle_inputs();
        do_reset();
        bus_if.req0_valid = 1'b1; bus_if.req0_a = 3'd1; bus_if.req0_b = 3'd2;
        bus_if.req1_valid = 1'b1; bus_if.req1_a = 3'd3; bus_if.req1_b = 3'd4;
        bus_if.res_ready  = 1'b1;
        id_seen.delete();
        for (int i = 0; i < 8; i++) begin
            cycle();
            #1;
            if (bus_if.res_valid) id_seen.push_back(int'(bus_if.res_id));
        end
        check("tie_results", 32'(id_seen.size()), 32'd4);
        for (int i = 0; i < id_seen.size() && i < 4; i++)
            check("tie_id", 32'(id_seen[i]), 32'(i % 2));

        // Backpressure: result 5 held while requester 0 keeps changing operands.
        idle_inputs();
        do_reset();
        bus_if.req0_valid = 1'b1; bus_if.req0_a = 3'd2; bus_if.req0_b = 3'd3;
        cycle();
        for (int i = 0; i < 10; i++) begin
            bus_if.req0_a = 3'($urandom_range(7, 0));
            bus_if.req0_b = 3'($urandom_range(7, 0));
            bus_if.req1_valid = (i % 2 == 0);
            cycle();
            #1;
            check("bp_data",   32'(bus_if.res_data),   32'd5);
            check("bp_ready0", 32'(bus_if.req0_ready), 32'd0);
            check("bp_ready1", 32'(bus_if.req1_ready), 32'd0);
            check("bp_count",  32'(bus_if.res_count),  32'd0);
        end
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
        bus_if.res_ready  = 1'b1;
        cycle();
        check("bp_delivered", 32'(bus_if.res_count), 32'd1);

        // Reset while a result is held: outputs clear at once, next tie goes to requester 0.
        idle_inputs();
        bus_if.req1_valid = 1'b1; bus_if.req1_a = 3'd6; bus_if.req1_b = 3'd1;
        cycle();
        bus_if.req0_valid = 1'b1;
        #2;
        check("hold_before_reset", 32'(bus_if.res_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_res_valid", 32'(bus_if.res_valid),  32'd0);
        check("rst_res_data",  32'(bus_if.res_data),   32'd0);
        check("rst_res_id",    32'(bus_if.res_id),     32'd0);
        check("rst_res_count", 32'(bus_if.res_count),  32'd0);
        check("rst_ready0",    32'(bus_if.req0_ready), 32'd0);
        check("rst_ready1",    32'(bus_if.req1_ready), 32'd0);
        @(negedge clock);
        cycle();
        reset = 1'b0;
        #1;
        check("post_rst_ready0", 32'(bus_if.req0_ready), 32'd1);
        check("post_rst_ready1", 32'(bus_if.req1_ready), 32'd0);
        cycle();

        // Randomized traffic with occasional resets.
        idle_inputs();
        for (int i = 0; i < 2000; i++) begin
            reset             = ($urandom_range(49, 0) == 0);
            bus_if.req0_valid = 1'($urandom_range(1, 0));
            bus_if.req0_a     = 3'($urandom_range(7, 0));
            bus_if.req0_b     = 3'($urandom_range(7, 0));
            bus_if.req1_valid = 1'($urandom_range(1, 0));
            bus_if.req1_a     = 3'($urandom_range(7, 0));
            bus_if.req1_b     = 3'($urandom_range(7, 0));
            bus_if.res_ready  = ($urandom_range(3, 0) != 0);
            cycle();
        end
        reset = 1'b0;

        // Counter wrap: 256 deliveries bring res_count back to zero.
        idle_inputs();
        do_reset();
        bus_if.req0_valid = 1'b1; bus_if.req0_a = 3'd1;
        bus_if.res_ready  = 1'b1;
        for (int i = 0; i < 510; i++) cycle();
        check("wrap_255", 32'(bus_if.res_count), 32'd255);
        cycle();
        cycle();
        check("wrap_0", 32'(bus_if.res_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
